leitor_tabuleiro: RTL and testbench

Read-side companion to the move-verification block. The verifier writes 4-bit cell values into the 324-bit player board. This block reads cells back out of that board for the display and status logic, in one of two modes:
- Single cell: random access by linha/coluna (1..9).
- Full scan: streams all 81 cells in row-major order over a valid/ready handshake.
For every cell it emits the empty flag and a match-against-solution flag. In scan mode it also accumulates per-board counts.

---
 rtl/leitor_tabuleiro.sv | 143 ++++++++++++++
 tb/tb_leitor_tabuleiro.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_tabuleiro.sv
// leitor_tabuleiro: reads cells back out of the player board, either one
// cell by position or a row-major scan of all cells over valid/ready.
module leitor_tabuleiro #(
  parameter int LINHAS  = 9,
  parameter int COLUNAS = 9,
  parameter int LARGURA = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [0:LINHAS*COLUNAS*LARGURA-1]     sudokuJogador,
  input  logic [0:LINHAS*COLUNAS*LARGURA-1]     sudokuCompleto,
  input  logic                                  start,
  input  logic                                  modo,
  input  logic [3:0]                            linha,
  input  logic [3:0]                            coluna,
  input  logic                                  ready,
  output logic                                  valid,
  output logic [LARGURA-1:0]                    valor,
  output logic [3:0]                            linhaOut,
  output logic [3:0]                            colunaOut,
  output logic                                  vazia,
  output logic                                  correta,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  erroPos,
  output logic [6:0]                            contaVazias,
  output logic [6:0]                            contaAcertos
);

  localparam int W  = LINHAS*COLUNAS*LARGURA;
  localparam int LW = COLUNAS*LARGURA;

  typedef enum logic [1:0] {IDLE, EMIT, FIM} estado_t;

  estado_t            estado, prox;
  logic [0:W-1]       snapJ, snapC;
  logic [3:0]         lin, col;
  logic               modo_r;
  logic               done_r, erro_r;
  logic [6:0]         cv, ca;
  logic [8:0]         idx;
  logic [LARGURA-1:0] cel, sol;
  logic               pos_ok, xfer, ultimo;

  always_comb begin
    idx = 9'((int'(lin) - 1) * LW + (int'(col) - 1) * LARGURA);
    cel = snapJ[idx +: LARGURA];
    sol = snapC[idx +: LARGURA];
  end

  assign pos_ok = (linha != 4'd0) && (linha <= 4'(LINHAS)) &&
                  (coluna != 4'd0) && (coluna <= 4'(COLUNAS));

  assign valid     = (estado == EMIT);
  assign valor     = valid ? cel : '0;
  assign linhaOut  = valid ? lin : 4'd0;
  assign colunaOut = valid ? col : 4'd0;
  assign vazia     = valid && (cel == '0);
  assign correta   = valid && (cel != '0) && (cel == sol);
  assign busy      = (estado != IDLE);
  assign done      = done_r;
  assign erroPos   = erro_r;
  assign contaVazias  = cv;
  assign contaAcertos = ca;

  assign xfer   = valid && ready;
  assign ultimo = !modo_r ||
                  ((lin == 4'(LINHAS)) && (col == 4'(COLUNAS)));

  always_comb begin
    prox = estado;
    unique case (estado)
      IDLE: if (start && (modo || pos_ok)) prox = EMIT;
      EMIT: if (xfer && ultimo) prox = FIM;
      FIM:  prox = IDLE;
      default: prox = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) estado <= IDLE;
    else       estado <= prox;
  end

  // Data path: snapshot, cursor and scan counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snapJ  <= '0;
      snapC  <= '0;
      lin    <= 4'd0;
      col    <= 4'd0;
      modo_r <= 1'b0;
      done_r <= 1'b0;
      erro_r <= 1'b0;
      cv     <= 7'd0;
      ca     <= 7'd0;
    end else begin
      done_r <= 1'b0;
      erro_r <= 1'b0;
      unique case (estado)
        IDLE: begin
          if (start) begin
            if (modo || pos_ok) begin
              snapJ  <= sudokuJogador;
              snapC  <= sudokuCompleto;
              modo_r <= modo;
              if (modo) begin
                lin <= 4'd1;
                col <= 4'd1;
                cv  <= 7'd0;
                ca  <= 7'd0;
              end else begin
                lin <= linha;
                col <= coluna;
              end
            end else begin
              erro_r <= 1'b1;
              done_r <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (xfer) begin
            if (modo_r) begin
              cv <= cv + 7'(vazia);
              ca <= ca + 7'(correta);
            end
            if (ultimo) begin
              done_r <= 1'b1;
            end else if (col == 4'(COLUNAS)) begin
              lin <= lin + 4'd1;
              col <= 4'd1;
            end else begin
              col <= col + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_tabuleiro.sv
// tb_leitor_tabuleiro: single-cell table, directed scans and randomized
// scans checked against a cell-array model of the boards.
module tb_leitor_tabuleiro;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [0:323] sudokuJogador, sudokuCompleto;
  logic         start, modo, ready;
  logic [3:0]   linha, coluna;
  logic         valid, vazia, correta, busy, done, erroPos;
  logic [3:0]   valor, linhaOut, colunaOut;
  logic [6:0]   contaVazias, contaAcertos;

  always #5 clk = ~clk;

  leitor_tabuleiro dut (
    .clk(clk), .rstn(rstn),
    .sudokuJogador(sudokuJogador), .sudokuCompleto(sudokuCompleto),
    .start(start), .modo(modo), .linha(linha), .coluna(coluna),
    .ready(ready), .valid(valid), .valor(valor),
    .linhaOut(linhaOut), .colunaOut(colunaOut),
    .vazia(vazia), .correta(correta), .busy(busy), .done(done),
    .erroPos(erroPos), .contaVazias(contaVazias),
    .contaAcertos(contaAcertos)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_v = 0;
  int exp_a = 0;

  logic [3:0] pj[1:9][1:9];
  logic [3:0] ps[1:9][1:9];

  typedef struct {
    int l; int c; int v; int s;
    bit vz; bit cr; bit err;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load();
    for (int l = 1; l <= 9; l++)
      for (int c = 1; c <= 9; c++) begin
        sudokuJogador[(l-1)*36 + (c-1)*4 +: 4]  = pj[l][c];
        sudokuCompleto[(l-1)*36 + (c-1)*4 +: 4] = ps[l][c];
      end
  endtask

  task automatic rand_boards();
    for (int l = 1; l <= 9; l++)
      for (int c = 1; c <= 9; c++) begin
        ps[l][c] = 4'($urandom_range(1, 9));
        case ($urandom_range(0, 3))
          0: pj[l][c] = 4'd0;
          1: pj[l][c] = 4'($urandom_range(0, 15));
          default: pj[l][c] = ps[l][c];
        endcase
      end
  endtask

  task automatic single(input vec_t t);
    @(negedge clk);
    modo = 1'b0; linha = 4'(t.l); coluna = 4'(t.c);
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (t.err) begin
      chk("bad_erro", int'(erroPos), 1);
      chk("bad_done", int'(done), 1);
      chk("bad_valid", int'(valid), 0);
      chk("bad_busy", int'(busy), 0);
      @(negedge clk);
      chk("bad_erro_end", int'(erroPos), 0);
      chk("bad_done_end", int'(done), 0);
      chk("bad_valid2", int'(valid), 0);
    end else begin
      chk("sg_valid", int'(valid), 1);
      chk("sg_valor", int'(valor), t.v);
      chk("sg_linha", int'(linhaOut), t.l);
      chk("sg_coluna", int'(colunaOut), t.c);
      chk("sg_vazia", int'(vazia), int'(t.vz));
      chk("sg_correta", int'(correta), int'(t.cr));
      chk("sg_busy", int'(busy), 1);
      @(negedge clk);
      chk("sg_done", int'(done), 1);
      chk("sg_valid_end", int'(valid), 0);
      @(negedge clk);
      chk("sg_done_end", int'(done), 0);
      chk("sg_idle", int'(busy), 0);
    end
    chk("sg_cntv", int'(contaVazias), exp_v);
    chk("sg_cnta", int'(contaAcertos), exp_a);
  endtask

  // mode 0: always ready, 1: random ready,
  // 2: stall 3 cycles on (2,1), 3: live board change + start mid-scan
  task automatic scan(input int mode);
    int idx, cyc, held, ev, ea, el, ec, v, s;
    bit rdy, hooked;
    ev = 0; ea = 0;
    for (int l = 1; l <= 9; l++)
      for (int c = 1; c <= 9; c++) begin
        if (pj[l][c] == 4'd0) ev++;
        else if (pj[l][c] == ps[l][c]) ea++;
      end
    load();
    @(negedge clk);
    modo = 1'b1; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0; held = 0; hooked = 0;
    while (idx < 81 && cyc < 3000) begin
      cyc++;
      el = idx / 9 + 1;
      ec = idx % 9 + 1;
      v = int'(pj[el][ec]);
      s = int'(ps[el][ec]);
      chk("sc_valid", int'(valid), 1);
      chk("sc_linha", int'(linhaOut), el);
      chk("sc_coluna", int'(colunaOut), ec);
      chk("sc_valor", int'(valor), v);
      chk("sc_vazia", int'(vazia), int'(v == 0));
      chk("sc_correta", int'(correta), int'(v != 0 && v == s));
      chk("sc_busy", int'(busy), 1);
      rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 2 && idx == 9 && held < 3) begin
        rdy = 1'b0;
        held++;
      end
      start = 1'b0;
      if (mode == 3 && idx == 20 && !hooked) begin
        sudokuJogador[4*36 + 4*4 +: 4] = 4'd9;
        start = 1'b1;
        hooked = 1;
      end
      ready = rdy;
      if (rdy) idx++;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b0;
    chk("sc_count", idx, 81);
    if (mode == 0) chk("sc_cycles", cyc, 81);
    if (mode == 2) chk("sc_stall", held, 3);
    chk("sc_done", int'(done), 1);
    chk("sc_valid_end", int'(valid), 0);
    chk("sc_cntv", int'(contaVazias), ev);
    chk("sc_cnta", int'(contaAcertos), ea);
    @(negedge clk);
    chk("sc_done_end", int'(done), 0);
    chk("sc_idle", int'(busy), 0);
    chk("sc_cntv_hold", int'(contaVazias), ev);
    exp_v = ev;
    exp_a = ea;
  endtask

  initial begin
    start = 1'b0; modo = 1'b0; ready = 1'b0;
    linha = 4'd0; coluna = 4'd0;
    sudokuJogador = '0; sudokuCompleto = '0;

    tab[0] = '{3, 5, 7, 7, 1'b0, 1'b1, 1'b0};
    tab[1] = '{1, 1, 0, 0, 1'b1, 1'b0, 1'b0};
    tab[2] = '{9, 9, 12, 12, 1'b0, 1'b1, 1'b0};
    tab[3] = '{4, 2, 15, 3, 1'b0, 1'b0, 1'b0};
    tab[4] = '{0, 4, 0, 0, 1'b0, 1'b0, 1'b1};
    tab[5] = '{10, 1, 0, 0, 1'b0, 1'b0, 1'b1};
    tab[6] = '{5, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    tab[7] = '{9, 15, 0, 0, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cntv", int'(contaVazias), 0);
    chk("rst_cnta", int'(contaAcertos), 0);
    rstn = 1'b1;

    for (int l = 1; l <= 9; l++)
      for (int c = 1; c <= 9; c++) begin
        ps[l][c] = 4'((l + c) % 9 + 1);
        pj[l][c] = ps[l][c];
      end
    pj[1][1] = 4'd0;
    ps[9][9] = 4'd8;
    pj[9][9] = 4'd3;
    scan(0);
    chk("plan_cntv", int'(contaVazias), 1);
    chk("plan_cnta", int'(contaAcertos), 79);

    rand_boards();
    scan(2);

    rand_boards();
    pj[5][5] = 4'd4;
    scan(3);

    for (int r = 0; r < 3; r++) begin
      rand_boards();
      scan(1);
    end

    for (int i = 0; i < 8; i++) begin
      rand_boards();
      if (!tab[i].err) begin
        pj[tab[i].l][tab[i].c] = 4'(tab[i].v);
        ps[tab[i].l][tab[i].c] = 4'(tab[i].s);
      end
      load();
      single(tab[i]);
    end

    rand_boards();
    load();
    @(negedge clk);
    modo = 1'b1; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_linha", int'(linhaOut), 5);
    chk("mid_coluna", int'(colunaOut), 5);
    rstn = 1'b0;
    #1;
    chk("ar_valid", int'(valid), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_cntv", int'(contaVazias), 0);
    chk("ar_cnta", int'(contaAcertos), 0);
    @(negedge clk);
    rstn = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    chk("ar_idle", int'(busy), 0);
    chk("ar_nodone", int'(done), 0);
    chk("ar_novalid", int'(valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
